// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : IF1 PC sequencing controller (redirect priority, idle parking)
// Revision   : 1.0
// ============================================================================
module fetch_ctrl #(
   parameter logic [31:0] PC_INITIAL = 32'h1c00_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        icache_ready_i,
   input  logic        if1_stall_i,
   input  logic        bp_taken_i,
   input  logic [31:0] bp_target_i,
   input  logic        ex_redirect_i,
   input  logic [31:0] ex_target_i,
   input  logic        csr_redirect_i,
   input  logic [31:0] csr_target_i,
   input  logic        idle_req_i,
   input  logic [31:0] idle_pc_i,
   input  logic        int_wakeup_i,
   output logic        pc_wen_o,
   output logic        is_branch_o,
   output logic [31:0] branch_address_o,
   output logic        pc_is_wrong_o,
   output logic [31:0] pc_correct_o,
   output logic        flush_if_o,
   output logic        fetch_valid_o,
   output logic [31:0] cur_target_o,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT_RD = 2'd1,
      ST_IDLE    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        pend_v_q, pend_v_d;
   logic        pend_csr_q, pend_csr_d;
   logic        pend_idle_q, pend_idle_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [31:0] cur_target_q, cur_target_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic        in_idle;
   logic        live_csr;
   logic        live_idle;
   logic        live_ex;
   logic [31:0] live_csr_tgt;

   logic        redir;
   logic        win_live;
   logic        win_csr;
   logic        win_idle;
   logic [31:0] win_tgt;
   logic        run_wen;

   // idle_req rides the CSR class; while parked only a CSR redirect is heard
   always_comb begin
      in_idle      = (state_q == ST_IDLE);
      live_csr     = csr_redirect_i | (idle_req_i & ~in_idle);
      live_idle    = idle_req_i & ~csr_redirect_i & ~in_idle;
      live_csr_tgt = csr_redirect_i ? csr_target_i : idle_pc_i;
      live_ex      = ex_redirect_i & ~in_idle;
   end

   // Winner: live CSR > pending CSR > live EX > pending EX
   always_comb begin
      redir    = 1'b1;
      win_live = 1'b1;
      win_csr  = 1'b1;
      win_idle = 1'b0;
      win_tgt  = pend_tgt_q;
      if (live_csr) begin
         win_tgt  = live_csr_tgt;
         win_idle = live_idle;
      end else if (pend_v_q && pend_csr_q) begin
         win_live = 1'b0;
         win_idle = pend_idle_q;
      end else if (live_ex) begin
         win_csr  = 1'b0;
         win_tgt  = ex_target_i;
      end else if (pend_v_q) begin
         win_live = 1'b0;
         win_csr  = 1'b0;
      end else begin
         redir    = 1'b0;
         win_live = 1'b0;
         win_csr  = 1'b0;
      end
   end

   always_comb begin
      state_d       = state_q;
      pend_v_d      = pend_v_q;
      pend_csr_d    = pend_csr_q;
      pend_idle_d   = pend_idle_q;
      pend_tgt_d    = pend_tgt_q;
      cur_target_d  = cur_target_q;
      pc_wen_o      = 1'b0;
      is_branch_o   = 1'b0;
      pc_is_wrong_o = 1'b0;
      flush_if_o    = 1'b0;
      fetch_valid_o = 1'b0;
      run_wen       = icache_ready_i & ~if1_stall_i;

      if (redir) begin
         // Flush only when the event first shows up; a delayed apply is silent
         pc_wen_o      = icache_ready_i;
         pc_is_wrong_o = icache_ready_i;
         flush_if_o    = win_live;
         if (icache_ready_i) begin
            pend_v_d     = 1'b0;
            pend_csr_d   = 1'b0;
            pend_idle_d  = 1'b0;
            cur_target_d = win_tgt;
            state_d      = win_idle ? ST_IDLE : ST_RUN;
         end else begin
            pend_v_d     = 1'b1;
            pend_csr_d   = win_csr;
            pend_idle_d  = win_idle;
            pend_tgt_d   = win_tgt;
            state_d      = ST_WAIT_RD;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (int_wakeup_i) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               pc_wen_o      = run_wen;
               is_branch_o   = bp_taken_i & run_wen;
               fetch_valid_o = 1'b1;
               state_d       = ST_RUN;
            end
         endcase
      end

      if (!rst_ni) begin
         pc_wen_o      = 1'b0;
         is_branch_o   = 1'b0;
         pc_is_wrong_o = 1'b0;
         flush_if_o    = 1'b0;
         fetch_valid_o = 1'b0;
      end

      stall_cnt_d = pc_wen_o ? stall_cnt_q : stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= ST_RUN;
         pend_v_q     <= 1'b0;
         pend_csr_q   <= 1'b0;
         pend_idle_q  <= 1'b0;
         pend_tgt_q   <= 32'd0;
         cur_target_q <= PC_INITIAL;
         stall_cnt_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         pend_v_q     <= pend_v_d;
         pend_csr_q   <= pend_csr_d;
         pend_idle_q  <= pend_idle_d;
         pend_tgt_q   <= pend_tgt_d;
         cur_target_q <= cur_target_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign branch_address_o = bp_target_i;
   assign pc_correct_o     = win_tgt;
   assign cur_target_o     = cur_target_q;
   assign stall_cnt_o      = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// tb_fetch_ctrl : scoreboard bench; a redirect-priority model feeds expected
// responses into a queue that a negedge monitor drains.
module tb_fetch_ctrl;
   localparam logic [31:0] PC_INIT = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        rst_n, icache_ready, if1_stall, bp_taken, ex_redirect;
   logic        csr_redirect, idle_req, int_wakeup;
   logic [31:0] bp_target, ex_target, csr_target, idle_pc;
   logic        pc_wen, is_branch, pc_is_wrong, flush_if, fetch_valid;
   logic [31:0] branch_address, pc_correct, cur_target, stall_cnt;

   always #5 clk = ~clk;

   fetch_ctrl #(.PC_INITIAL(PC_INIT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .icache_ready_i(icache_ready),
      .if1_stall_i(if1_stall), .bp_taken_i(bp_taken), .bp_target_i(bp_target),
      .ex_redirect_i(ex_redirect), .ex_target_i(ex_target),
      .csr_redirect_i(csr_redirect), .csr_target_i(csr_target),
      .idle_req_i(idle_req), .idle_pc_i(idle_pc), .int_wakeup_i(int_wakeup),
      .pc_wen_o(pc_wen), .is_branch_o(is_branch), .branch_address_o(branch_address),
      .pc_is_wrong_o(pc_is_wrong), .pc_correct_o(pc_correct), .flush_if_o(flush_if),
      .fetch_valid_o(fetch_valid), .cur_target_o(cur_target), .stall_cnt_o(stall_cnt)
   );

   typedef struct {
      bit          pc_wen;
      bit          is_branch;
      bit          pc_is_wrong;
      bit          flush_if;
      bit          fetch_valid;
      logic [31:0] branch_address;
      logic [31:0] pc_correct;
      logic [31:0] cur_target;
      logic [31:0] stall_cnt;
   } exp_t;

   typedef struct {
      bit          live;
      bit          csr;
      bit          idle;
      logic [31:0] tgt;
   } redir_t;

   exp_t        exp_q[$];
   redir_t      m_pend[$];
   bit          m_parked = 1'b0;
   logic [31:0] m_cur    = PC_INIT;
   logic [31:0] m_stall  = 32'd0;
   int          n_cmp    = 0;
   int          n_bad    = 0;

   // Model: list every candidate in priority order, the head of the list wins
   task automatic push();
      exp_t   e;
      redir_t c[$];
      redir_t r;
      e.pc_wen         = 1'b0;
      e.is_branch      = 1'b0;
      e.pc_is_wrong    = 1'b0;
      e.flush_if       = 1'b0;
      e.fetch_valid    = 1'b0;
      e.branch_address = bp_target;
      e.pc_correct     = 32'd0;
      e.cur_target     = m_cur;
      e.stall_cnt      = m_stall;
      if (!rst_n) begin
         m_parked = 1'b0;
         m_pend.delete();
         m_cur    = PC_INIT;
         m_stall  = 32'd0;
      end else begin
         if (csr_redirect)
            c.push_back('{live: 1'b1, csr: 1'b1, idle: 1'b0, tgt: csr_target});
         else if (idle_req && !m_parked)
            c.push_back('{live: 1'b1, csr: 1'b1, idle: 1'b1, tgt: idle_pc});
         if (m_pend.size() != 0 && m_pend[0].csr)
            c.push_back(m_pend[0]);
         if (ex_redirect && !m_parked)
            c.push_back('{live: 1'b1, csr: 1'b0, idle: 1'b0, tgt: ex_target});
         if (m_pend.size() != 0)
            c.push_back(m_pend[0]);

         if (c.size() != 0) begin
            r             = c[0];
            e.pc_wen      = icache_ready;
            e.pc_is_wrong = icache_ready;
            e.flush_if    = r.live;
            e.pc_correct  = r.tgt;
            m_pend.delete();
            if (icache_ready) begin
               m_cur    = r.tgt;
               m_parked = r.idle;
            end else begin
               r.live   = 1'b0;
               m_pend.push_back(r);
               m_parked = 1'b0;
            end
         end else if (m_parked) begin
            if (int_wakeup) m_parked = 1'b0;
         end else begin
            e.pc_wen      = icache_ready && !if1_stall;
            e.is_branch   = bp_taken && e.pc_wen;
            e.fetch_valid = 1'b1;
         end
         if (!e.pc_wen) m_stall = m_stall + 32'd1;
      end
      exp_q.push_back(e);
   endtask

   task automatic chk1(input string nm, input logic act, input bit exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk1("pc_wen", pc_wen, e.pc_wen);
            chk1("is_branch", is_branch, e.is_branch);
            chk1("pc_is_wrong", pc_is_wrong, e.pc_is_wrong);
            chk1("flush_if", flush_if, e.flush_if);
            chk1("fetch_valid", fetch_valid, e.fetch_valid);
            chk32("cur_target", cur_target, e.cur_target);
            chk32("stall_cnt", stall_cnt, e.stall_cnt);
            if (e.is_branch) chk32("branch_address", branch_address, e.branch_address);
            if (e.pc_is_wrong) chk32("pc_correct", pc_correct, e.pc_correct);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst_n        = 1'b1;
      icache_ready = 1'b1;
      if1_stall    = 1'b0;
      bp_taken     = 1'b0;
      ex_redirect  = 1'b0;
      csr_redirect = 1'b0;
      idle_req     = 1'b0;
      int_wakeup   = 1'b0;
   endtask

   initial begin : stimulus
      int guard;
      quiet();
      rst_n      = 1'b0;
      bp_target  = 32'd0;
      ex_target  = 32'd0;
      csr_target = 32'd0;
      idle_pc    = 32'd0;

      for (int i = 0; i < 3; i++) begin
         tick(); quiet(); rst_n = 1'b0; push();
      end
      tick(); quiet(); push();

      // predicted branch, then the same with downstream stalled
      tick(); quiet(); bp_taken = 1'b1; bp_target = 32'h1c00_0100; push();
      tick(); quiet(); bp_taken = 1'b1; bp_target = 32'h1c00_0100; if1_stall = 1'b1; push();

      // EX redirect held off by the icache for three cycles
      tick(); quiet(); ex_redirect = 1'b1; ex_target = 32'h1c00_0040; icache_ready = 1'b0; push();
      for (int i = 0; i < 2; i++) begin
         tick(); quiet(); icache_ready = 1'b0; bp_taken = 1'b1; push();
      end
      tick(); quiet(); push();

      // CSR beats EX live; pending CSR beats a later live EX
      tick(); quiet(); csr_redirect = 1'b1; csr_target = 32'h1c00_8000;
      ex_redirect = 1'b1; ex_target = 32'h1c00_0040; bp_taken = 1'b1; push();
      tick(); quiet(); csr_redirect = 1'b1; csr_target = 32'h1c00_8000; icache_ready = 1'b0; push();
      tick(); quiet(); ex_redirect = 1'b1; ex_target = 32'h1c00_0040; icache_ready = 1'b0; push();
      tick(); quiet(); push();

      // idle park, ignored EX, wakeup
      tick(); quiet(); idle_req = 1'b1; idle_pc = 32'h1c00_0200; push();
      for (int i = 0; i < 10; i++) begin
         tick(); quiet(); bp_taken = 1'b1; ex_redirect = (i == 4); ex_target = 32'h1c00_0444; push();
      end
      tick(); quiet(); int_wakeup = 1'b1; push();
      tick(); quiet(); push();

      // idle_req together with CSR: CSR wins, no park
      tick(); quiet(); idle_req = 1'b1; idle_pc = 32'h1c00_0300;
      csr_redirect = 1'b1; csr_target = 32'h1c00_9000; push();
      tick(); quiet(); push();

      // stall counter wrap
      tick(); quiet(); icache_ready = 1'b0;
      force dut.stall_cnt_q = 32'hffff_ffff;
      #1;
      release dut.stall_cnt_q;
      m_stall = 32'hffff_ffff;
      push();
      tick(); quiet(); push();

      for (int i = 0; i < 3000; i++) begin
         tick();
         rst_n        = ($urandom_range(0, 99) != 0);
         icache_ready = ($urandom_range(0, 3) != 0);
         if1_stall    = ($urandom_range(0, 3) == 0);
         bp_taken     = ($urandom_range(0, 1) == 1);
         ex_redirect  = ($urandom_range(0, 9) == 0);
         csr_redirect = ($urandom_range(0, 19) == 0);
         idle_req     = ($urandom_range(0, 29) == 0);
         int_wakeup   = ($urandom_range(0, 14) == 0);
         bp_target    = $urandom;
         ex_target    = $urandom;
         csr_target   = $urandom;
         idle_pc      = $urandom;
         push();
      end
      tick(); quiet(); push();

      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d responses left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
